// File: rtl/spi_seq_pkg.sv
// ----------------------------------------------------------------------------
// spi_seq_pkg
// Shared types for the SPI transfer sequencer: FSM state enum, the transfer
// type encodings driven on spi_top's req input, and the completion rule that
// says which done strobes a given transfer type has to see.
// ----------------------------------------------------------------------------
package spi_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitDone,
      StResp
   } seq_state_e;

   localparam logic [1:0] REQ_NONE   = 2'b00;
   localparam logic [1:0] REQ_M2S    = 2'b01;
   localparam logic [1:0] REQ_S2M    = 2'b10;
   localparam logic [1:0] REQ_DUPLEX = 2'b11;

   // True once every done strobe required by the transfer type has been seen.
   function automatic logic xfer_complete(input logic [1:0] i_typ,
                                          input logic       i_tx,
                                          input logic       i_rx);
      logic w_ok;
      case (i_typ)
         REQ_M2S:    w_ok = i_tx;
         REQ_S2M:    w_ok = i_rx;
         REQ_DUPLEX: w_ok = i_tx & i_rx;
         default:    w_ok = 1'b0;
      endcase
      return w_ok;
   endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// ----------------------------------------------------------------------------
// spi_cmd_fifo
// Synchronous FIFO for queued SPI commands. DEPTH must be a power of two so
// the read/write pointers wrap for free.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_push, i_data      write strobe and entry (ignored when full)
//   i_pop               read strobe (ignored when empty)
//   o_data              head entry
//   o_full, o_empty     status
//   o_count             number of stored entries
// ----------------------------------------------------------------------------
module spi_cmd_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];

   // Storage needs no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// ----------------------------------------------------------------------------
// spi_xfer_sequencer
// Queues SPI transfer commands and plays them one at a time into spi_top:
// pops a command, pulses req for one cycle, waits for the done strobe(s) the
// transfer type needs (or a timeout), then presents a response until taken.
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_req,
//   cmd_wait, cmd_din_m, cmd_din_s        command handshake and payload
//   req, wait_duration,
//   din_master, din_slave                 drive spi_top
//   dout_master, dout_slave,
//   done_tx, done_rx                      results and strobes from spi_top
//   rsp_valid/rsp_ready, rsp_dout_m,
//   rsp_dout_s, rsp_err                   response handshake and payload
//   busy, fifo_count                      status
// ----------------------------------------------------------------------------
module spi_xfer_sequencer
   import spi_seq_pkg::*;
#(
   parameter int unsigned SPI_TRF_BIT = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_req,
   input  logic [7:0]                    cmd_wait,
   input  logic [SPI_TRF_BIT-1:0]        cmd_din_m,
   input  logic [SPI_TRF_BIT-1:0]        cmd_din_s,
   output logic [1:0]                    req,
   output logic [7:0]                    wait_duration,
   output logic [SPI_TRF_BIT-1:0]        din_master,
   output logic [SPI_TRF_BIT-1:0]        din_slave,
   input  logic [SPI_TRF_BIT-1:0]        dout_master,
   input  logic [SPI_TRF_BIT-1:0]        dout_slave,
   input  logic                          done_tx,
   input  logic                          done_rx,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [SPI_TRF_BIT-1:0]        rsp_dout_m,
   output logic [SPI_TRF_BIT-1:0]        rsp_dout_s,
   output logic                          rsp_err,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned FW = 2 + 8 + 2 * SPI_TRF_BIT;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   seq_state_e              r_state;
   seq_state_e              w_state_nxt;

   logic [FW-1:0]           w_fifo_wdata;
   logic [FW-1:0]           w_fifo_rdata;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic                    w_push;
   logic                    w_pop;

   logic [1:0]              r_typ;
   logic [7:0]              r_wait;
   logic [SPI_TRF_BIT-1:0]  r_din_m;
   logic [SPI_TRF_BIT-1:0]  r_din_s;
   logic                    r_tx_seen;
   logic                    r_rx_seen;
   logic [TW-1:0]           r_tmo_cnt;
   logic [SPI_TRF_BIT-1:0]  r_rsp_m;
   logic [SPI_TRF_BIT-1:0]  r_rsp_s;
   logic                    r_rsp_err;

   logic                    w_in_wait;
   logic                    w_done;
   logic                    w_tmo;

   // Held low during reset so no command can be taken while rst is high.
   assign cmd_ready    = !w_fifo_full && !rst;
   // No-op commands complete the handshake but are dropped here.
   assign w_push       = cmd_valid && cmd_ready && (cmd_req != REQ_NONE);
   assign w_pop        = (r_state == StIdle) && !w_fifo_empty;
   assign w_fifo_wdata = {cmd_req, cmd_wait, cmd_din_m, cmd_din_s};

   spi_cmd_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_fifo_wdata),
      .i_pop   (w_pop),
      .o_data  (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (fifo_count)
   );

   // A strobe arriving in the completing cycle counts, so same-cycle
   // done_tx/done_rx finish a duplex transfer immediately.
   assign w_in_wait = (r_state == StWaitDone);
   assign w_done    = w_in_wait && xfer_complete(r_typ, r_tx_seen | done_tx,
                                                 r_rx_seen | done_rx);
   assign w_tmo     = w_in_wait && !w_done && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:     if (!w_fifo_empty) w_state_nxt = StIssue;
         StIssue:    w_state_nxt = StWaitDone;
         StWaitDone: if (w_done || w_tmo) w_state_nxt = StResp;
         StResp:     if (rsp_ready) w_state_nxt = StIdle;
         default:    w_state_nxt = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      req           = (r_state == StIssue) ? r_typ : REQ_NONE;
      rsp_valid     = (r_state == StResp);
      busy          = (r_state != StIdle);
      wait_duration = r_wait;
      din_master    = r_din_m;
      din_slave     = r_din_s;
      rsp_dout_m    = r_rsp_m;
      rsp_dout_s    = r_rsp_s;
      rsp_err       = r_rsp_err;
   end

   // Holding registers, sticky done flags, timeout counter, response capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_typ     <= REQ_NONE;
         r_wait    <= '0;
         r_din_m   <= '0;
         r_din_s   <= '0;
         r_tx_seen <= 1'b0;
         r_rx_seen <= 1'b0;
         r_tmo_cnt <= '0;
         r_rsp_m   <= '0;
         r_rsp_s   <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         if (w_pop) begin
            {r_typ, r_wait, r_din_m, r_din_s} <= w_fifo_rdata;
            r_tx_seen <= 1'b0;
            r_rx_seen <= 1'b0;
            r_tmo_cnt <= '0;
         end else if (w_in_wait) begin
            r_tx_seen <= r_tx_seen | done_tx;
            r_rx_seen <= r_rx_seen | done_rx;
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         end
         if (w_done) begin
            r_rsp_m   <= dout_master;
            r_rsp_s   <= dout_slave;
            r_rsp_err <= 1'b0;
         end else if (w_tmo) begin
            r_rsp_m   <= '0;
            r_rsp_s   <= '0;
            r_rsp_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter SPI_TRF_BIT, default 8, transfer width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, 2..16).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, maximum clk cycles to wait for done.
REQ-004 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have cmd_valid  input  1 and cmd_ready  output  1 for the command handshake.
REQ-007 SHALL have cmd_req  input  2  transfer type: 01 M->S, 10 S->M, 11 full duplex, 00 no-op.
REQ-008 SHALL have cmd_wait  input  8  wait_duration value for this transfer.
REQ-009 SHALL have cmd_din_m and cmd_din_s  input  SPI_TRF_BIT  master and slave payloads.
REQ-010 SHALL have req  output  2, wait_duration  output  8, din_master and din_slave  output  SPI_TRF_BIT, all driving spi_top.
REQ-011 SHALL have dout_master and dout_slave  input  SPI_TRF_BIT, and done_tx and done_rx  input  1, all from spi_top.
REQ-012 SHALL have rsp_valid  output  1 and rsp_ready  input  1 for the response handshake.
REQ-013 SHALL have rsp_dout_m and rsp_dout_s  output  SPI_TRF_BIT, and rsp_err  output  1 (timeout).
REQ-014 SHALL have busy  output  1 and fifo_count  output  $clog2(FIFO_DEPTH)+1.

Function
REQ-015 A command SHALL be accepted on a clk edge with cmd_valid && cmd_ready; cmd_ready = !fifo_full.
REQ-016 An accepted command with cmd_req=00 SHALL be discarded and not enqueued.
REQ-017 The FIFO SHALL be first-in first-out with wrapping pointers; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and RESP.
REQ-019 IDLE->ISSUE SHALL occur when the FIFO is non-empty; the head SHALL be popped into holding registers on that edge.
REQ-020 In ISSUE, req SHALL equal the held type for exactly one cycle, then return to 00; the FSM SHALL then move to WAIT_DONE.
REQ-021 din_master, din_slave and wait_duration SHALL be held stable from ISSUE until the FSM leaves RESP.
REQ-022 In WAIT_DONE, done_tx and done_rx SHALL be latched in independent sticky flags.
REQ-023 Completion SHALL be: type 01 needs tx_seen; type 10 needs rx_seen; type 11 needs both, in either order or in the same cycle.
REQ-024 On completion, dout_master and dout_slave SHALL be captured into rsp_dout_m and rsp_dout_s, rsp_err=0, and the FSM SHALL enter RESP.
REQ-025 If TIMEOUT_CYC cycles elapse in WAIT_DONE without completion, the FSM SHALL enter RESP with rsp_err=1 and both rsp_dout fields 0.
REQ-026 In RESP, rsp_valid SHALL be 1 and response fields SHALL be stable; the FSM SHALL return to IDLE on rsp_valid && rsp_ready.
REQ-027 done_tx and done_rx pulses outside WAIT_DONE SHALL be ignored.
REQ-028 busy SHALL be 1 whenever the state is not IDLE.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, and sticky flags and the timeout counter SHALL clear.
REQ-030 On rst, all outputs SHALL be 0, except cmd_ready which SHALL be 1 after rst deasserts.
REQ-031 Reset mid-transfer SHALL abort the transfer with no response issued.

Structure
REQ-032 The package spi_seq_pkg SHALL hold the FSM state enum and the req encodings (REQ_NONE, REQ_M2S, REQ_S2M, REQ_DUPLEX).
REQ-033 The FIFO SHALL be a separate sub-module, spi_cmd_fifo, parameterised on width and depth.

Verification
REQ-034 Push {01, wait=10, din_m=0xB8} -> one-cycle req=01; after done_tx, rsp_dout_s=0xB8, rsp_err=0.
REQ-035 Push {11, din_m=0x5A, din_s=0xA2}, done_rx arriving before done_tx -> single response with rsp_dout_m=0xA2 and rsp_dout_s=0x5A.
REQ-036 Push 5 commands with rsp_ready=0 -> cmd_ready low once the FIFO is full; responses then drain in push order.
REQ-037 Push {10} with done_rx held low -> rsp_err=1 exactly TIMEOUT_CYC cycles after ISSUE.
REQ-038 Assert rst during WAIT_DONE -> all outputs 0 on the next cycle, fifo_count=0, no rsp_valid.
REQ-039 Push {00} -> accepted, fifo_count stays 0, req never asserted.
